// File: rtl/xdiv_seq_pkg.sv
// xdiv_seq_pkg: shared definitions for the xdiv_seq radix-2 restoring divider.
//   - xdiv_state_e : controller state encoding (2 bits)
//   - xdiv_cnt_w() : iteration counter width, $clog2(DATA_W+1)
package xdiv_seq_pkg;

  localparam int unsigned XDIV_STATE_W = 2;

  typedef enum logic [XDIV_STATE_W-1:0] {
    XDIV_IDLE = 2'd0,
    XDIV_CALC = 2'd1,
    XDIV_FIX  = 2'd2,
    XDIV_DONE = 2'd3
  } xdiv_state_e;

  // Counter must be able to hold DATA_W itself.
  function automatic int unsigned xdiv_cnt_w(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/xdiv_seq_negc.sv
// xdiv_seq_negc: conditional two's-complement negate, y_c = neg ? -x : x.
// Ports:
//   neg  in  1  negate request
//   x    in  W  operand
//   y_c  out W  combinational result
module xdiv_seq_negc #(
  parameter int unsigned W = 8
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y_c
);

  assign y_c = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/xdiv_seq.sv
// xdiv_seq: multi-cycle integer divider, radix-2 restoring, one quotient bit
// per clock, start/busy/done handshake.
// Build option: define XDIV_SIGNED_EN to honour sgn (two's-complement mode,
// abs/negate logic and ovf detection). Without it the divider is unsigned only,
// sgn is ignored and ovf is tied low; latency is identical.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request, sampled only in IDLE
//   sgn               1 = signed operands (sampled with start)
//   dividend/divisor  DATA_W operands (sampled with start)
//   busy              high whenever not IDLE
//   done              one-cycle pulse when results are written
//   q, r              quotient / remainder, held until the next result
//   dz, ovf           divide-by-zero / signed overflow, held with results
module xdiv_seq
  import xdiv_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sgn,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] r,
  output logic              dz,
  output logic              ovf
);

  localparam int unsigned CNT_W = xdiv_cnt_w(DATA_W);
  localparam int unsigned SR_W  = 2 * DATA_W;

  xdiv_state_e       state_q;
  xdiv_state_e       state_d;
  logic              busy_d;
  logic              done_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [SR_W-1:0]   sr_q;       // {partial remainder, quotient}
  logic [SR_W-1:0]   sr_step;
  logic [DATA_W-1:0] dvs_q;      // divisor magnitude
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] dvd_mag;
  logic [DATA_W-1:0] dvs_mag;
  logic [DATA_W-1:0] q_fin;
  logic [DATA_W-1:0] r_fin;
  logic              divisor_zero;

  assign divisor_zero = (divisor == '0);

`ifdef XDIV_SIGNED_EN
  logic dvd_neg;
  logic dvs_neg;
  logic ovf_det;
  logic qneg_q;
  logic rneg_q;
  logic ovf_pend_q;

  assign dvd_neg = sgn & dividend[DATA_W-1];
  assign dvs_neg = sgn & divisor[DATA_W-1];
  // Only most-negative / -1 overflows; the magnitude path then yields 2^(W-1).
  assign ovf_det = sgn & (dividend == {1'b1, {(DATA_W-1){1'b0}}}) & (divisor == '1);

  xdiv_seq_negc #(.W(DATA_W)) u_dvd_abs (.neg(dvd_neg), .x(dividend), .y_c(dvd_mag));
  xdiv_seq_negc #(.W(DATA_W)) u_dvs_abs (.neg(dvs_neg), .x(divisor),  .y_c(dvs_mag));
  xdiv_seq_negc #(.W(DATA_W)) u_q_fix   (.neg(qneg_q), .x(sr_step[DATA_W-1:0]),    .y_c(q_fin));
  xdiv_seq_negc #(.W(DATA_W)) u_r_fix   (.neg(rneg_q), .x(sr_step[SR_W-1:DATA_W]), .y_c(r_fin));
`else
  logic sgn_unused;

  assign sgn_unused = sgn;
  assign dvd_mag    = dividend;
  assign dvs_mag    = divisor;
  assign q_fin      = sr_step[DATA_W-1:0];
  assign r_fin      = sr_step[SR_W-1:DATA_W];
`endif

  // One restoring step: shift left, trial-subtract in DATA_W+1 bits.
  always_comb begin
    diff = sr_q[SR_W-1:DATA_W-1] - {1'b0, dvs_q};
    if (diff[DATA_W]) begin
      sr_step = {sr_q[SR_W-2:0], 1'b0};
    end else begin
      sr_step = {diff[DATA_W-1:0], sr_q[DATA_W-2:0], 1'b1};
    end
  end

  // State register plus registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= XDIV_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next state. CALC runs DATA_W-1 steps; FIX performs the last step together
  // with the sign fix-up so that done lands in cycle DATA_W+1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      XDIV_IDLE: if (start) state_d = divisor_zero ? XDIV_DONE : XDIV_CALC;
      XDIV_CALC: if (cnt_q == CNT_W'(2)) state_d = XDIV_FIX;
      XDIV_FIX:  state_d = XDIV_DONE;
      XDIV_DONE: state_d = XDIV_IDLE;
      default:   state_d = XDIV_IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state, registered above.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    busy_d = (state_d != XDIV_IDLE);
    done_d = (state_d == XDIV_DONE);
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      sr_q       <= '0;
      dvs_q      <= '0;
      q          <= '0;
      r          <= '0;
      dz         <= 1'b0;
      ovf        <= 1'b0;
`ifdef XDIV_SIGNED_EN
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        XDIV_IDLE: begin
          if (start) begin
            cnt_q <= CNT_W'(DATA_W);
            sr_q  <= {DATA_W'(0), dvd_mag};
            dvs_q <= dvs_mag;
`ifdef XDIV_SIGNED_EN
            qneg_q     <= dvd_neg ^ dvs_neg;
            rneg_q     <= dvd_neg;
            ovf_pend_q <= ovf_det;
`endif
            if (divisor_zero) begin
              q   <= '1;
              r   <= dividend;
              dz  <= 1'b1;
              ovf <= 1'b0;
            end
          end
        end
        XDIV_CALC: begin
          sr_q  <= sr_step;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        XDIV_FIX: begin
          sr_q <= sr_step;
          q    <= q_fin;
          r    <= r_fin;
          dz   <= 1'b0;
`ifdef XDIV_SIGNED_EN
          ovf  <= ovf_pend_q;
`else
          ovf  <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xdiv_seq.sv
// tb_xdiv_seq: self-checking bench for xdiv_seq (DATA_W=8 and DATA_W=16
// instances) against a plain-arithmetic reference model.
module tb_xdiv_seq;

  localparam int W     = 8;
  localparam int LIMIT = 40;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sgn;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         dz;
  logic         ovf;

  logic         start16;
  logic         sgn16;
  logic [15:0]  dividend16;
  logic [15:0]  divisor16;
  logic         busy16;
  logic         done16;
  logic [15:0]  q16;
  logic [15:0]  r16;
  logic         dz16;
  logic         ovf16;

  int n_cmp = 0;
  int n_bad = 0;

  xdiv_seq #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .q(q), .r(r), .dz(dz), .ovf(ovf)
  );

  xdiv_seq #(.DATA_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sgn(sgn16),
    .dividend(dividend16), .divisor(divisor16),
    .busy(busy16), .done(done16), .q(q16), .r(r16), .dz(dz16), .ovf(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: truncating division on mathematical integers.
  function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] eq, output logic [W-1:0] er,
                                  output logic edz, output logic eovf);
    longint sa, sb, qq, rr;
    logic   se;
`ifdef XDIV_SIGNED_EN
    se = s;
`else
    se = 1'b0;
`endif
    edz  = 1'b0;
    eovf = 1'b0;
    if (b == '0) begin
      eq  = '1;
      er  = a;
      edz = 1'b1;
    end else begin
      if (se) begin
        sa = $signed(a);
        sb = $signed(b);
      end else begin
        sa = longint'(a);
        sb = longint'(b);
      end
      qq = sa / sb;
      rr = sa % sb;
      if (se && sa == -(longint'(1) << (W - 1)) && sb == -1) eovf = 1'b1;
      eq = W'(qq);
      er = W'(rr);
    end
  endfunction

  // Issues one operation from IDLE and returns in the done cycle (or at LIMIT).
  task automatic drive_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_bad);
    sgn = s; dividend = a; divisor = b; start = 1'b1;
    tick();
    start = 1'b0; sgn = 1'($urandom); dividend = W'($urandom); divisor = W'($urandom);
    lat = 1;
    busy_bad = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      if (busy !== 1'b1) busy_bad++;
      tick();
      lat++;
    end
    if (busy !== 1'b1) busy_bad++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sgn = 1'b0; dividend = '0; divisor = '0;
    start16 = 1'b0; sgn16 = 1'b0; dividend16 = '0; divisor16 = '0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, q, r, dz, ovf} !== '0) begin
      n_bad++;
      $display("FAIL reset8: busy=%b done=%b q=%h r=%h dz=%b ovf=%b, required all 0", busy, done, q, r, dz, ovf);
    end
    n_cmp++;
    if ({busy16, done16, q16, r16, dz16, ovf16} !== '0) begin
      n_bad++;
      $display("FAIL reset16: busy=%b done=%b q=%h r=%h, required all 0", busy16, done16, q16, r16);
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta [0:9];
    logic [7:0] tb_ [0:9];
    logic       ts [0:9];
    logic [7:0] eq_t [0:9];
    logic [7:0] er_t [0:9];
    logic [W-1:0] eq, er;
    logic edz, eovf;
    int lat, bb, elat;
    ta   = '{8'd100, 8'd156, 8'd100, 8'd156, 8'd128, 8'd128, 8'd55, 8'd55, 8'hF0, 8'd0};
    tb_  = '{8'd7,   8'd7,   8'd249, 8'd249, 8'd255, 8'd255, 8'd0,  8'd0,  8'h02, 8'd5};
    ts   = '{1'b0,   1'b1,   1'b1,   1'b1,   1'b1,   1'b0,   1'b0,  1'b1,  1'b1,  1'b1};
`ifdef XDIV_SIGNED_EN
    eq_t = '{8'h0E, 8'hF2, 8'hF2, 8'h0E, 8'h80, 8'h00, 8'hFF, 8'hFF, 8'hF8, 8'h00};
    er_t = '{8'h02, 8'hFE, 8'h02, 8'hFE, 8'h00, 8'h80, 8'h37, 8'h37, 8'h00, 8'h00};
`else
    eq_t = '{8'h0E, 8'h16, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h78, 8'h00};
    er_t = '{8'h02, 8'h02, 8'h64, 8'h9C, 8'h80, 8'h80, 8'h37, 8'h37, 8'h00, 8'h00};
`endif
    for (int i = 0; i < 10; i++) begin
      drive_op(ts[i], ta[i], tb_[i], lat, bb);
      ref_div(ts[i], ta[i], tb_[i], eq, er, edz, eovf);
      elat = (tb_[i] == 8'd0) ? 1 : W + 1;
      n_cmp++;
      if ({q, r} !== {eq_t[i], er_t[i]}) begin
        n_bad++;
        $display("FAIL dir%0d_qr: q=%h r=%h, required q=%h r=%h", i, q, r, eq_t[i], er_t[i]);
      end
      n_cmp++;
      if ({dz, ovf} !== {edz, eovf}) begin
        n_bad++;
        $display("FAIL dir%0d_flags: dz=%b ovf=%b, required dz=%b ovf=%b", i, dz, ovf, edz, eovf);
      end
      n_cmp++;
      if (lat != elat || bb != 0) begin
        n_bad++;
        $display("FAIL dir%0d_timing: done cycle %0d busy_gaps %0d, required cycle %0d gaps 0", i, lat, bb, elat);
      end
      tick();
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
        n_bad++;
        $display("FAIL dir%0d_idle: busy=%b done=%b, required 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, eq, er;
    logic s, edz, eovf;
    int lat, bb, sel;
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel == 0) b = '0;
      if (sel == 1) b = '1;
      if (sel == 2) a = {1'b1, {(W-1){1'b0}}};
      if (sel == 3) begin a = {1'b1, {(W-1){1'b0}}}; b = '1; end
      drive_op(s, a, b, lat, bb);
      ref_div(s, a, b, eq, er, edz, eovf);
      n_cmp++;
      if ({q, r, dz, ovf} !== {eq, er, edz, eovf}) begin
        n_bad++;
        $display("FAIL rnd%0d s=%b %h/%h: q=%h r=%h dz=%b ovf=%b, required q=%h r=%h dz=%b ovf=%b",
                 i, s, a, b, q, r, dz, ovf, eq, er, edz, eovf);
      end
      n_cmp++;
      if (lat != ((b == '0) ? 1 : W + 1) || bb != 0) begin
        n_bad++;
        $display("FAIL rnd%0d_timing: done cycle %0d busy_gaps %0d", i, lat, bb);
      end
      tick();
    end
  endtask

  task automatic test_start_while_busy();
    int lat, extra;
    sgn = 1'b0; dividend = 8'd200; divisor = 8'd9; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    tick(); tick(); lat = 3;
    sgn = 1'b0; dividend = 8'd50; divisor = 8'd0; start = 1'b1;
    tick(); lat = 4;
    start = 1'b0;
    while (done !== 1'b1 && lat < LIMIT) begin tick(); lat++; end
    n_cmp++;
    if (lat != W + 1 || {q, r, dz} !== {8'd22, 8'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL busy_start: done cycle %0d q=%0d r=%0d dz=%b, required cycle %0d q=22 r=2 dz=0", lat, q, r, dz, W + 1);
    end
    extra = 0;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL busy_start_queued: %0d active cycles after done, required 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    sgn = 1'b0; dividend = 8'd200; divisor = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, q, r, dz, ovf} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid: busy=%b done=%b q=%h r=%h dz=%b ovf=%b, required all 0", busy, done, q, r, dz, ovf);
    end
    seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL rst_mid_abort: %0d active cycles after reset, required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bb;
    drive_op(1'b0, 8'd77, 8'd5, lat, bb);
    n_cmp++;
    if ({q, r, lat} !== {8'd15, 8'd2, W + 1}) begin
      n_bad++;
      $display("FAIL b2b_first: q=%0d r=%0d cycle %0d, required 15 2 %0d", q, r, lat, W + 1);
    end
    sgn = 1'b0; dividend = 8'd200; divisor = 8'd0; start = 1'b1;
    tick();
    n_cmp++;
    if ({busy, done, q} !== {1'b0, 1'b0, 8'd15}) begin
      n_bad++;
      $display("FAIL b2b_done_start: busy=%b done=%b q=%0d, required 0 0 15", busy, done, q);
    end
    sgn = 1'b0; dividend = 8'd90; divisor = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({busy, q, r} !== {1'b1, 8'd15, 8'd2}) begin
      n_bad++;
      $display("FAIL b2b_hold: busy=%b q=%0d r=%0d, required 1 15 2", busy, q, r);
    end
    lat = 1;
    while (done !== 1'b1 && lat < LIMIT) begin tick(); lat++; end
    n_cmp++;
    if ({q, r} !== {8'd22, 8'd2} || lat != W + 1) begin
      n_bad++;
      $display("FAIL b2b_second: q=%0d r=%0d cycle %0d, required 22 2 %0d", q, r, lat, W + 1);
    end
    tick();
  endtask

  task automatic test_w16();
    logic [15:0] ta [0:1];
    logic [15:0] tb_ [0:1];
    int lat;
    ta  = '{16'd65535, 16'd50000};
    tb_ = '{16'd255,   16'd7};
    for (int i = 0; i < 2; i++) begin
      sgn16 = 1'b0; dividend16 = ta[i]; divisor16 = tb_[i]; start16 = 1'b1;
      tick();
      start16 = 1'b0; dividend16 = 16'($urandom); divisor16 = 16'($urandom);
      lat = 1;
      while (done16 !== 1'b1 && lat < LIMIT) begin tick(); lat++; end
      n_cmp++;
      if ({q16, r16, dz16, ovf16} !== {ta[i] / tb_[i], ta[i] % tb_[i], 1'b0, 1'b0} || lat != 17) begin
        n_bad++;
        $display("FAIL w16_%0d: q=%0d r=%0d dz=%b cycle %0d, required q=%0d r=%0d dz=0 cycle 17",
                 i, q16, r16, dz16, lat, ta[i] / tb_[i], ta[i] % tb_[i]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_w16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
